// File: rtl/mem_stage_param_if.sv
// Bundle of the EX->MEM pipeline fields, the registered MEM->WB fields and the
// external asynchronous SRAM pins seen by mem_stage_param.
interface mem_stage_param_if #(
  parameter int DW    = 16,
  parameter int AW    = 18,
  parameter int OPW   = 4,
  parameter int DESTW = 3,
  parameter int WAIT  = 3
);
  localparam int CW = $clog2(WAIT);

  logic [OPW-1:0]   opcode_in;
  logic [DW-1:0]    alu_res_in;
  logic [DW-1:0]    store_data_in;
  logic [DESTW-1:0] dest_in;
  logic             mem_write_en_in;
  logic             wb_mux_in;
  logic             wb_en_in;

  logic             wb_mux_out;
  logic             wb_en_out;
  logic [DESTW-1:0] dest_out;
  logic [DW-1:0]    alu_res_out;
  logic [DW-1:0]    mem_data_out;
  logic [OPW-1:0]   opcode_out;
  logic             ready;

  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_dq_o;
  logic             sram_dq_oe;
  logic [DW-1:0]    sram_dq_i;
  logic             sram_ce_n;
  logic             sram_oe_n;
  logic             sram_we_n;
  logic             sram_ub_n;
  logic             sram_lb_n;
  logic [CW-1:0]    wait_cnt;

  // master: the upstream stage together with the SRAM device
  modport master (
    output opcode_in, alu_res_in, store_data_in, dest_in, mem_write_en_in,
           wb_mux_in, wb_en_in, sram_dq_i,
    input  wb_mux_out, wb_en_out, dest_out, alu_res_out, mem_data_out,
           opcode_out, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n,
           sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, wait_cnt
  );

  modport slave (
    input  opcode_in, alu_res_in, store_data_in, dest_in, mem_write_en_in,
           wb_mux_in, wb_en_in, sram_dq_i,
    output wb_mux_out, wb_en_out, dest_out, alu_res_out, mem_data_out,
           opcode_out, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n,
           sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, wait_cnt
  );
endinterface

// File: rtl/mem_stage_param.sv
// MEM pipeline stage: ALU ops pass through in one cycle, loads/stores stall the
// pipe for a fixed WAIT-cycle access to an asynchronous SRAM.
module mem_stage_param #(
  parameter int DW    = 16,
  parameter int AW    = 18,
  parameter int OPW   = 4,
  parameter int DESTW = 3,
  parameter int WAIT  = 3,
  parameter int OP_LD = 10,
  parameter int OP_ST = 11
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_param_if.slave bus
);
  localparam int            CW   = $clog2(WAIT);
  localparam logic [CW-1:0]  LAST = CW'(WAIT - 1);
  localparam logic [OPW-1:0] LD   = OPW'(OP_LD);
  localparam logic [OPW-1:0] ST   = OPW'(OP_ST);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    sdata_q, sdata_d;
  logic [DESTW-1:0] dest_q, dest_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             wb_mux_q, wb_mux_d;
  logic             wb_en_q, wb_en_d;
  logic             is_write_q, is_write_d;

  logic [OPW-1:0]   opcode_out_q, opcode_out_d;
  logic [DW-1:0]    alu_res_out_q, alu_res_out_d;
  logic [DW-1:0]    mem_data_out_q, mem_data_out_d;
  logic [DESTW-1:0] dest_out_q, dest_out_d;
  logic             wb_mux_out_q, wb_mux_out_d;
  logic             wb_en_out_q, wb_en_out_d;

  logic is_mem_in;
  logic in_access;
  logic retire;

  assign is_mem_in = (bus.opcode_in == LD) || (bus.opcode_in == ST);
  assign in_access = (state_q == ACCESS);
  assign retire    = in_access && (wait_cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      addr_q         <= '0;
      sdata_q        <= '0;
      dest_q         <= '0;
      op_q           <= '0;
      wb_mux_q       <= 1'b0;
      wb_en_q        <= 1'b0;
      is_write_q     <= 1'b0;
      opcode_out_q   <= '0;
      alu_res_out_q  <= '0;
      mem_data_out_q <= '0;
      dest_out_q     <= '0;
      wb_mux_out_q   <= 1'b0;
      wb_en_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      addr_q         <= addr_d;
      sdata_q        <= sdata_d;
      dest_q         <= dest_d;
      op_q           <= op_d;
      wb_mux_q       <= wb_mux_d;
      wb_en_q        <= wb_en_d;
      is_write_q     <= is_write_d;
      opcode_out_q   <= opcode_out_d;
      alu_res_out_q  <= alu_res_out_d;
      mem_data_out_q <= mem_data_out_d;
      dest_out_q     <= dest_out_d;
      wb_mux_out_q   <= wb_mux_out_d;
      wb_en_out_q    <= wb_en_out_d;
    end
  end

  // WB fields default to a bubble; only a pass-through or a retirement fills them.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    addr_d         = addr_q;
    sdata_d        = sdata_q;
    dest_d         = dest_q;
    op_d           = op_q;
    wb_mux_d       = wb_mux_q;
    wb_en_d        = wb_en_q;
    is_write_d     = is_write_q;
    opcode_out_d   = '0;
    alu_res_out_d  = '0;
    mem_data_out_d = '0;
    dest_out_d     = '0;
    wb_mux_out_d   = 1'b0;
    wb_en_out_d    = 1'b0;
    if (state_q == IDLE) begin
      if (is_mem_in) begin
        addr_d     = bus.alu_res_in;
        sdata_d    = bus.store_data_in;
        dest_d     = bus.dest_in;
        op_d       = bus.opcode_in;
        wb_mux_d   = bus.wb_mux_in;
        wb_en_d    = bus.wb_en_in;
        is_write_d = (bus.opcode_in == ST) && bus.mem_write_en_in;
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end else begin
        opcode_out_d   = bus.opcode_in;
        alu_res_out_d  = bus.alu_res_in;
        mem_data_out_d = bus.sram_dq_i;
        dest_out_d     = bus.dest_in;
        wb_mux_out_d   = bus.wb_mux_in;
        wb_en_out_d    = bus.wb_en_in;
      end
    end else if (retire) begin
      opcode_out_d   = op_q;
      alu_res_out_d  = addr_q;
      mem_data_out_d = (op_q == LD) ? bus.sram_dq_i : '0;
      dest_out_d     = dest_q;
      wb_mux_out_d   = wb_mux_q;
      wb_en_out_d    = wb_en_q;
      wait_cnt_d     = '0;
      state_d        = IDLE;
    end else begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // The write strobe is released in the last access cycle so data is held past it.
  always_comb begin
    bus.ready        = (state_q == IDLE) ? !is_mem_in : retire;
    bus.sram_addr    = in_access ? AW'(addr_q) : AW'(bus.alu_res_in);
    bus.sram_ce_n    = !in_access;
    bus.sram_oe_n    = !(in_access && !is_write_q && (op_q == LD));
    bus.sram_we_n    = !(in_access && is_write_q && (wait_cnt_q != LAST));
    bus.sram_dq_oe   = in_access && is_write_q;
    bus.sram_dq_o    = (in_access && is_write_q) ? sdata_q : '0;
    bus.sram_ub_n    = 1'b0;
    bus.sram_lb_n    = 1'b0;
    bus.wait_cnt     = wait_cnt_q;
    bus.opcode_out   = opcode_out_q;
    bus.alu_res_out  = alu_res_out_q;
    bus.mem_data_out = mem_data_out_q;
    bus.dest_out     = dest_out_q;
    bus.wb_mux_out   = wb_mux_out_q;
    bus.wb_en_out    = wb_en_out_q;
  end
endmodule

// File: doc/mem_stage_param.md
MEM_STAGE_PARAM -- requirements
Module: mem_stage_param

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DW, 16, data and ALU-result width
- AW, 18, SRAM address width; must be >= DW
- OPW, 4, opcode width
- DESTW, 3, destination-register width
- WAIT, 3, SRAM cycles per access after acceptance; must be >= 2
- OP_LD, 10, load opcode
- OP_ST, 11, store opcode
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- opcode_in, in, OPW, EX opcode
- alu_res_in, in, DW, address or ALU result
- store_data_in, in, DW, store data
- dest_in, in, DESTW, destination register
- mem_write_en_in, in, 1, store qualifier
- wb_mux_in, in, 1, writeback select
- wb_en_in, in, 1, writeback enable
- wb_mux_out, out, 1, registered to WB
- wb_en_out, out, 1, registered to WB
- dest_out, out, DESTW, registered to WB
- alu_res_out, out, DW, registered to WB
- mem_data_out, out, DW, registered to WB
- opcode_out, out, OPW, registered to WB
- ready, out, 1, combinational; high = current op retires at next edge
- sram_addr, out, AW, SRAM address
- sram_dq_o, out, DW, write data
- sram_dq_oe, out, 1, data-bus drive enable
- sram_dq_i, in, DW, read data
- sram_ce_n, sram_oe_n, sram_we_n, out, 1 each, SRAM strobes, active-low
- sram_ub_n, sram_lb_n, out, 1 each, byte lanes; constant 0
- wait_cnt, out, ceil(log2(WAIT)), access counter for debug

Function
REQ-003 SHALL implement FSM states IDLE and ACCESS.
REQ-004 In IDLE with a non-memory opcode:
- ready=1.
- At the edge, register all *_in fields to the matching *_out; mem_data_out = sram_dq_i.
- Remain in IDLE.
REQ-005 In IDLE with opcode_in equal to OP_LD or OP_ST:
- ready=0.
- At the edge, latch alu_res_in, store_data_in, dest_in, wb_mux_in, wb_en_in and opcode_in.
- Latch is_write = (opcode_in==OP_ST) && mem_write_en_in.
- wait_cnt=0; go to ACCESS; drive all *_out to 0 (bubble).
REQ-006 In ACCESS:
- wait_cnt increments each cycle.
- ready=1 only when wait_cnt==WAIT-1.
- *_out stay 0 until retirement.
REQ-007 Retirement, at the edge where wait_cnt==WAIT-1:
- Register latched fields to *_out.
- mem_data_out = sram_dq_i for LD, 0 for ST.
- Return to IDLE with wait_cnt=0.
REQ-008 A LD/ST SHALL occupy exactly WAIT+1 cycles from acceptance to retirement (4 at defaults).
REQ-009 Back-to-back memory ops: the next op is sampled in the first IDLE cycle after retirement; the FSM never skips IDLE.
REQ-010 Upstream SHALL hold all inputs while ready=0; changes to inputs during ACCESS SHALL have no effect.
REQ-011 sram_addr SHALL be the zero-extended latched address during ACCESS, and zero-extended alu_res_in in IDLE.
REQ-012 sram_ce_n SHALL be 0 only in ACCESS.
REQ-013 sram_oe_n SHALL be 0 only in ACCESS with is_write=0.
REQ-014 For is_write=1 in ACCESS:
- sram_dq_oe=1 and sram_dq_o = latched store data for every ACCESS cycle.
- sram_we_n=0 while wait_cnt<WAIT-1.
- sram_we_n=1 in the final cycle, giving data hold time.
REQ-015 In IDLE: sram_ce_n=sram_oe_n=sram_we_n=1 and sram_dq_oe=0.
REQ-016 An OP_ST with mem_write_en_in=0 SHALL run the full access timing with no write strobe and no read strobe.
REQ-017 wait_cnt SHALL wrap only via the return to IDLE; it never exceeds WAIT-1.

Reset
REQ-018 When rst=1 at an edge:
- state=IDLE, wait_cnt=0.
- All *_out = 0; sram_dq_o = 0.
- Strobes sram_ce_n, sram_oe_n, sram_we_n deasserted (1); sram_dq_oe=0.
- Applies even mid-ACCESS: no retirement, no further write strobe.
REQ-019 In the cycle after reset, with no memory op presented, ready SHALL be 1.

Verification
REQ-020 Scenarios the bench SHALL cover:
- ALU op (opcode 9, alu_res_in=0x1234, dest 5, wb_en 1) in IDLE -> next cycle alu_res_out=0x1234, dest_out=5, wb_en_out=1; ready stays 1.
- LD at address 0x0040 with sram_dq_i=0xBEEF, defaults -> ready=0 for 3 cycles then 1; mem_data_out=0xBEEF 4 edges after acceptance; sram_oe_n=0 for 3 cycles; sram_we_n stays 1.
- ST 0xA5A5 to 0x0010 with mem_write_en_in=1 -> sram_we_n=0 at wait_cnt 0 and 1, 1 at wait_cnt 2; sram_dq_oe=1 for all 3 ACCESS cycles; sram_dq_o=0xA5A5 throughout.
- LD immediately followed by ST -> ST accepted in the first IDLE cycle after LD retirement; total 8 cycles; no strobe overlap.
- rst asserted at wait_cnt=1 of a ST -> next cycle sram_we_n=1, sram_dq_oe=0, all outputs 0, state IDLE, no retirement.
- WAIT=5 build, LD -> ready low for 5 cycles; retirement 6 edges after acceptance.
